fir_rx_decim: RTL and testbench
===============================

Name: fir_rx_decim

Overview:
Consumer on the far end of the FIR output stream. It accepts the full-precision filter output, which has valid only and no backpressure. Each sample is rounded, shifted and saturated to a narrower word, then decimated by a fixed ratio. Kept samples are buffered in a FIFO and presented on an AXI-stream master port with tready backpressure toward the downstream radar processing chain (FFT / packetiser). Sticky overflow and fill-level status are provided for software.

Parameters:
IW, 24, input sample width (matches filter Nw+Cw default of 8+16)
OW, 16, output sample width
SHIFT, 8, right-shift applied before saturation (0 allowed)
DECIM, 4, decimation ratio (>=1; 1 = pass every sample)
DEPTH, 16, FIFO depth in words (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  IW  signed filtered sample
s_axis_tvalid  in  1  sample valid; no tready, every valid sample must be consumed
m_axis_tdata  out  OW  signed decimated sample
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
ovf_clr  in  1  single-cycle pulse, clears ovf
ovf  out  1  sticky: a kept sample was dropped because the FIFO was full
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, decimation counter 0, pipeline valids 0, ovf 0.
- Decimation counter:
  - Advances 0..DECIM-1 on each cycle with s_axis_tvalid=1; wraps to 0.
  - A sample is kept when the counter is 0 at acceptance, i.e. the 1st, (DECIM+1)th, ... valid samples after reset.
  - The counter never stalls.
- Stage 1 (registered), rounding:
  - r = (sign-extended input to IW+1 bits + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
  - Rounding is half-up. Skip the add when SHIFT=0.
- Stage 2 (registered), saturation:
  - Clamp r to [-2^(OW-1), 2^(OW-1)-1].
  - Issue a FIFO write request.
- Latency: a kept sample on s_axis at edge N is written to the FIFO at edge N+2. It appears on m_axis at edge N+3 if the FIFO was empty and no earlier word is pending.
- FIFO:
  - DEPTH words; read/write pointers carry one extra wrap bit; full and empty are derived from the pointers.
  - Output is registered, first-word-fall-through.
  - m_axis_tvalid stays high until the handshake (tvalid & tready). m_axis_tdata must be stable while tvalid=1 and tready=0.
  - On handshake, the next word is presented the following cycle if available; otherwise tvalid drops.
  - Back-to-back reads sustain 1 word/cycle.
  - The output register counts toward level and DEPTH.
- Full boundary:
  - A write with full=1 and no same-cycle read: sample dropped, ovf<=1, level unchanged.
  - A write with full=1 and a same-cycle handshake: write accepted, level unchanged, no ovf.
- Empty boundary: a write and a read in the same cycle while empty is impossible because tvalid=0. A write into an empty FIFO raises tvalid the next cycle.
- ovf: set has priority over ovf_clr in the same cycle.
- level: updates on the edge of each write/read; +1, -1 or 0 for simultaneous events.
- Reset mid-operation: in-flight pipeline samples and FIFO contents are discarded. After release, the first valid sample is kept.

Test Plan:
1. Rounding (DECIM=1, SHIFT=8): inputs 0x000180, 0xFFFF80, 0x00007F, tready=1 -> outputs 0x0002, 0x0000, 0x0000. First output valid exactly 3 cycles after first input.
2. Saturation: inputs 0x7FFFFF, 0x800000, 0x7F7F00 -> outputs 0x7FFF (clamped), 0x8000, 0x7F7F.
3. Decimation (DECIM=4): 8 consecutive valids with value k*256, k=1..8, including a gap cycle with tvalid=0 after k=3 -> outputs exactly 0x0001, 0x0005. Gap does not advance the counter.
4. Backpressure/overflow (DECIM=1): tready=0, 20 samples -> level=16, ovf=1, then pulse ovf_clr -> ovf=0. With tready=1, the 16 words drain in order (first 16 samples), one per cycle; level reaches 0 and tvalid drops.
5. Full with simultaneous read: hold level=16, then assert tready together with a new input -> level stays 16, ovf stays 0, new word delivered last.
6. Reset mid-stream: assert rstn=0 while level=5 and tvalid=1 -> tvalid, level and ovf go to 0 immediately. After release, the first input sample appears as the first output.

Source files
------------

// File: rtl/fir_rx_decim.sv
// Receive side of the FIR output stream: round, saturate and decimate the
// full-precision samples, then buffer them onto an AXI-stream master with backpressure.
module fir_rx_decim #(
    parameter int IW    = 24,
    parameter int OW    = 16,
    parameter int SHIFT = 8,
    parameter int DECIM = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [IW-1:0]              s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic [OW-1:0]              m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic                       ovf_clr,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [IW:0] SMAX = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] SMIN = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    // ---------------- decimation counter ----------------
    logic [CW-1:0] dcnt;
    logic          keep;

    assign keep = s_axis_tvalid && (dcnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
        end else if (s_axis_tvalid) begin
            if (dcnt == CW'(DECIM - 1))
                dcnt <= '0;
            else
                dcnt <= dcnt + CW'(1);
        end
    end

    // ---------------- stage 1: half-up rounding ----------------
    logic signed [IW:0] ext;
    logic signed [IW:0] rnd_val;
    logic signed [IW:0] s1_data;
    logic               s1_valid;

    assign ext = {s_axis_tdata[IW-1], s_axis_tdata};

    generate
        if (SHIFT > 0) begin : g_rnd
            localparam logic [IW:0] RND = {{IW{1'b0}}, 1'b1} << (SHIFT - 1);
            logic [IW:0] sum;
            assign sum     = ext + RND;
            assign rnd_val = $signed(sum) >>> SHIFT;
        end else begin : g_nornd
            assign rnd_val = ext;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= keep;
            if (keep)
                s1_data <= rnd_val;
        end
    end

    // ---------------- stage 2: saturation, FIFO write request ----------------
    logic [OW-1:0] sat_val;
    logic [OW-1:0] wr_data;
    logic          wr_req;

    always_comb begin
        sat_val = s1_data[OW-1:0];
        if (s1_data > SMAX)
            sat_val = SMAX[OW-1:0];
        else if (s1_data < SMIN)
            sat_val = SMIN[OW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_data <= '0;
            wr_req  <= 1'b0;
        end else begin
            wr_req <= s1_valid;
            if (s1_valid)
                wr_data <= sat_val;
        end
    end

    // ---------------- FIFO with registered FWFT output ----------------
    // Output handshake: a word transfers on a rising edge where m_axis_tvalid
    // and m_axis_tready are both 1; tvalid never drops and tdata never changes
    // before that edge. The output register is part of the occupancy.
    logic [OW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          mem_empty;
    logic          full;
    logic          hs;
    logic          wr_en;
    logic          ovf_set;
    logic          load;

    assign mem_empty = (wptr == rptr);
    assign full      = (level == LW'(DEPTH));
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign wr_en     = wr_req && (!full || hs);
    assign ovf_set   = wr_req && full && !hs;
    assign load      = !mem_empty && (!m_axis_tvalid || hs);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr          <= '0;
            rptr          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (wr_en)
                wptr <= wptr + (AW+1)'(1);
            if (load) begin
                rptr          <= rptr + (AW+1)'(1);
                m_axis_tdata  <= mem[rptr[AW-1:0]];
                m_axis_tvalid <= 1'b1;
            end else if (hs) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // ---------------- occupancy and sticky overflow ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= '0;
        end else begin
            case ({wr_en, hs})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear must remain visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fir_rx_decim.sv
// Bench for fir_rx_decim: a DECIM=1 and a DECIM=4 instance share the input stream,
// each with its own output scoreboard.
module tb_fir_rx_decim;

    localparam int IW = 24;
    localparam int OW = 16;
    localparam int LW = 5;

    logic          clk;
    logic          rstn;
    logic [IW-1:0] s_tdata;
    logic          s_tvalid;
    logic          ovf_clr;

    logic [OW-1:0] m_tdata1,  m_tdata4;
    logic          m_tvalid1, m_tvalid4;
    logic          m_tready1, m_tready4;
    logic          ovf1,      ovf4;
    logic [LW-1:0] level1,    level4;

    logic [OW-1:0] exp_q1[$];
    logic [OW-1:0] exp_q4[$];

    int n_checks;
    int n_errors;
    int n_hs1;
    int n_hs4;
    int cnt4;
    bit drop1;
    logic [OW-1:0] last_d1;

    fir_rx_decim #(.IW(IW), .OW(OW), .SHIFT(8), .DECIM(1), .DEPTH(16)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
        .ovf_clr(ovf_clr), .ovf(ovf1), .level(level1)
    );

    fir_rx_decim #(.IW(IW), .OW(OW), .SHIFT(8), .DECIM(4), .DEPTH(16)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready4),
        .ovf_clr(ovf_clr), .ovf(ovf4), .level(level4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model and checker ----------------
    function automatic logic [OW-1:0] model(input logic [IW-1:0] d);
        longint v;
        logic [63:0] u;
        v = longint'($signed(d));
        v = (v + 128) >>> 8;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        u = v;
        return u[OW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [IW-1:0] d);
        s_tdata  = d;
        s_tvalid = 1'b1;
        if (!drop1)
            exp_q1.push_back(model(d));
        if (cnt4 == 0)
            exp_q4.push_back(model(d));
        cnt4 = (cnt4 == 3) ? 0 : cnt4 + 1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q1.delete();
        exp_q4.delete();
        cnt4 = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rstn) begin
            if (m_tvalid1 && m_tready1) begin
                n_hs1++;
                last_d1 = m_tdata1;
                if (exp_q1.size() == 0)
                    chk("d1_extra", 32'(m_tdata1), 32'hdead);
                else
                    chk("d1_data", 32'(m_tdata1), 32'(exp_q1.pop_front()));
            end
            if (m_tvalid4 && m_tready4) begin
                n_hs4++;
                if (exp_q4.size() == 0)
                    chk("d4_extra", 32'(m_tdata4), 32'hdead);
                else
                    chk("d4_data", 32'(m_tdata4), 32'(exp_q4.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int waited;
        logic [IW-1:0] x;
        n_checks  = 0;
        n_errors  = 0;
        n_hs1     = 0;
        n_hs4     = 0;
        cnt4      = 0;
        drop1     = 1'b0;
        last_d1   = '0;
        rstn      = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        ovf_clr   = 1'b0;
        m_tready1 = 1'b1;
        m_tready4 = 1'b1;

        do_reset();
        chk("rst_tvalid", 32'(m_tvalid1), 0);
        chk("rst_tdata",  32'(m_tdata1),  0);
        chk("rst_level",  32'(level1),    0);
        chk("rst_ovf",    32'(ovf1),      0);

        // rounding and first-output latency
        send(24'h000180);
        send(24'hFFFF80);
        send(24'h00007F);
        @(negedge clk);
        chk("lat_pre", 32'(m_tvalid1), 0);
        @(negedge clk);
        chk("lat_at",  32'(m_tvalid1), 1);
        idle(6);

        // saturation
        send(24'h7FFFFF);
        send(24'h800000);
        send(24'h7F7F00);
        idle(6);
        chk("sat_q1_empty", 32'(exp_q1.size()), 0);

        // decimation with a gap after k=3
        do_reset();
        base = n_hs4;
        for (int k = 1; k <= 3; k++) send(IW'(k * 256));
        idle(1);
        for (int k = 4; k <= 8; k++) send(IW'(k * 256));
        idle(8);
        chk("decim_count", 32'(n_hs4 - base), 2);
        chk("decim_q4_empty", 32'(exp_q4.size()), 0);

        // fill with no backpressure relief, overflow, clear, drain
        do_reset();
        m_tready1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drop1 = (i >= 16);
            send(IW'((i + 1) * 256 + 37));
        end
        drop1 = 1'b0;
        idle(4);
        chk("ovf_level", 32'(level1), 16);
        chk("ovf_set",   32'(ovf1),   1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf1), 0);
        m_tready1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("drain_vld", 32'(m_tvalid1), 1);
        end
        @(negedge clk);
        chk("drain_vld_end", 32'(m_tvalid1), 0);
        chk("drain_level",   32'(level1),    0);
        chk("drain_q1_empty", 32'(exp_q1.size()), 0);
        idle(1);

        // full with a read on the same edge as the write
        m_tready1 = 1'b0;
        for (int i = 0; i < 16; i++) send(IW'(24'h100000 + i * 512));
        idle(4);
        chk("full_level_pre", 32'(level1), 16);
        x = 24'h3A5A00;
        send(x);
        @(posedge clk);
        #1;
        m_tready1 = 1'b1;
        @(posedge clk);
        #1;
        m_tready1 = 1'b0;
        chk("full_rd_level", 32'(level1), 16);
        chk("full_rd_ovf",   32'(ovf1),   0);
        m_tready1 = 1'b1;
        waited = 0;
        while ((exp_q1.size() != 0 || m_tvalid1) && waited < 60) begin
            idle(1);
            waited++;
        end
        chk("full_rd_drain_to", 32'(waited < 60), 1);
        chk("full_rd_last", 32'(last_d1), 32'(model(x)));
        chk("full_rd_level0", 32'(level1), 0);

        // reset in the middle of traffic
        m_tready1 = 1'b0;
        for (int i = 0; i < 5; i++) send(IW'(24'h020000 + i * 256));
        idle(4);
        chk("mid_level_pre", 32'(level1), 5);
        s_tdata  = 24'h055500;
        s_tvalid = 1'b1;
        #2;
        rstn = 1'b0;
        exp_q1.delete();
        exp_q4.delete();
        cnt4 = 0;
        #1;
        chk("mid_rst_tvalid", 32'(m_tvalid1), 0);
        chk("mid_rst_level",  32'(level1),    0);
        chk("mid_rst_ovf",    32'(ovf1),      0);
        idle(1);
        s_tvalid = 1'b0;
        idle(1);
        rstn = 1'b1;
        m_tready1 = 1'b1;
        base = n_hs1;
        send(24'h001300);
        send(24'hFFF000);
        send(24'h004400);
        idle(8);
        chk("post_rst_count", 32'(n_hs1 - base), 3);
        chk("post_rst_q1_empty", 32'(exp_q1.size()), 0);
        chk("end_q4_empty", 32'(exp_q4.size()), 0);
        chk("end_ovf4", 32'(ovf4), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
